c64_key_matrix: RTL and testbench

- Successor to the combinational key-code translator; adds state.
- Takes USB-HID-style key press/release events from the FPGA Companion and keeps a held-key matrix of ROWS x COLS keys, default 8x8.
- Answers CIA port scans in both directions: column-drive to row-sense, and row-drive to column-sense.
- Adds two functions the translator lacks:
  - virtual-shift keys: cursor up/left and F2/F4/F6/F8;
  - RESTORE/overrun handling.
- The code-to-position table stays external and is reached through a lookup port pair.

---
 rtl/c64_key_matrix.sv | 213 +++++++++++++++++++++
 tb/tb_c64_key_matrix.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c64_key_matrix.sv
// c64_key_matrix: held-key matrix for C64 keyboard emulation, fed by HID press/release events.
// Two-stage event pipeline with a 1-deep skid, virtual shift, RESTORE and overrun handling.
//
// state     | meaning
// ST_IDLE   | no event in the lookup stage (skid may still hold one)
// ST_LOOKUP | event code on lk_code; matrix update at end of this cycle
module c64_key_matrix #(
  parameter int                ROWS         = 8,
  parameter int                COLS         = 8,
  parameter int                CODE_W       = 7,
  parameter int                SHIFT_ROW    = 7,
  parameter int                SHIFT_COL    = 1,
  parameter logic [CODE_W-1:0] RESTORE_CODE = 7'h4a
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_strobe,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_pressed,
  output logic [CODE_W-1:0] lk_code,
  input  logic [2:0]        lk_row,
  input  logic [2:0]        lk_col,
  input  logic [COLS-1:0]   col_sel_n,
  output logic [ROWS-1:0]   row_sense_n,
  input  logic [ROWS-1:0]   row_sel_n,
  output logic [COLS-1:0]   col_sense_n,
  output logic              restore_n,
  output logic              busy
);

  localparam logic [CODE_W-1:0] CODE_OVERRUN = CODE_W'('h01);
  localparam logic [CODE_W-1:0] CODE_A_LO    = CODE_W'('h04);
  localparam logic [CODE_W-1:0] CODE_A_HI    = CODE_W'('h64);
  localparam logic [CODE_W-1:0] CODE_B_LO    = CODE_W'('h68);
  localparam logic [CODE_W-1:0] CODE_B_HI    = CODE_W'('h6f);
  localparam logic [CODE_W-1:0] CODE_LEFT    = CODE_W'('h50);
  localparam logic [CODE_W-1:0] CODE_UP      = CODE_W'('h52);
  localparam logic [CODE_W-1:0] CODE_F2      = CODE_W'('h3b);
  localparam logic [CODE_W-1:0] CODE_F4      = CODE_W'('h3d);
  localparam logic [CODE_W-1:0] CODE_F6      = CODE_W'('h3f);
  localparam logic [CODE_W-1:0] CODE_F8      = CODE_W'('h41);
  localparam logic [3:0]        ROWS_L       = 4'(ROWS);
  localparam logic [3:0]        COLS_L       = 4'(COLS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOOKUP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CODE_W-1:0] pipe_code;
  logic              pipe_press;
  logic [CODE_W-1:0] skid_code;
  logic              skid_press;
  logic              skid_vld;

  logic take_skid;
  logic take_in;
  logic fill_skid;
  logic apply;

  logic [ROWS-1:0][COLS-1:0] key_q;
  logic [ROWS-1:0][COLS-1:0] key_d;
  logic [ROWS-1:0][COLS-1:0] eff;
  logic [2:0]                vshift_q;
  logic [2:0]                vshift_d;
  logic                      restore_q;
  logic                      restore_d;

  logic is_matrix;
  logic is_vshift;
  logic in_range;

  logic [ROWS-1:0] row_hit;
  logic [COLS-1:0] col_hit;

  assign lk_code   = pipe_code;
  assign restore_n = restore_q;
  assign busy      = (state_q == ST_LOOKUP) | skid_vld;

  // A strobe seen while busy parks in the skid; one seen while the skid is full is lost.
  always_comb begin
    state_d   = state_q;
    take_skid = 1'b0;
    take_in   = 1'b0;
    fill_skid = 1'b0;
    apply     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (skid_vld) begin
          take_skid = 1'b1;
          state_d   = ST_LOOKUP;
        end else if (key_strobe) begin
          take_in = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        apply = 1'b1;
        if (skid_vld) begin
          take_skid = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
        if (key_strobe && !skid_vld) begin
          fill_skid = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pipe_code  <= '0;
      pipe_press <= 1'b0;
      skid_code  <= '0;
      skid_press <= 1'b0;
      skid_vld   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_skid) begin
        pipe_code  <= skid_code;
        pipe_press <= skid_press;
      end else if (take_in) begin
        pipe_code  <= key_code;
        pipe_press <= key_pressed;
      end
      if (fill_skid) begin
        skid_code  <= key_code;
        skid_press <= key_pressed;
      end
      skid_vld <= fill_skid | (skid_vld & ~take_skid);
    end
  end

  assign is_matrix = ((pipe_code >= CODE_A_LO) && (pipe_code <= CODE_A_HI)) ||
                     ((pipe_code >= CODE_B_LO) && (pipe_code <= CODE_B_HI));
  assign is_vshift = (pipe_code == CODE_LEFT) || (pipe_code == CODE_UP) ||
                     (pipe_code == CODE_F2)   || (pipe_code == CODE_F4) ||
                     (pipe_code == CODE_F6)   || (pipe_code == CODE_F8);
  assign in_range  = ({1'b0, lk_row} < ROWS_L) && ({1'b0, lk_col} < COLS_L);

  // RESTORE and overrun are decided on the code alone; the lookup result is ignored for them.
  always_comb begin
    key_d     = key_q;
    vshift_d  = vshift_q;
    restore_d = restore_q;
    if (apply) begin
      if (pipe_code == RESTORE_CODE) begin
        restore_d = ~pipe_press;
      end else if (pipe_code == CODE_OVERRUN) begin
        key_d    = '0;
        vshift_d = '0;
      end else if (is_matrix && in_range) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if ((3'(r) == lk_row) && (3'(c) == lk_col)) begin
              key_d[r][c] = pipe_press;
            end
          end
        end
        if (is_vshift) begin
          if (pipe_press) begin
            if (vshift_q != 3'd7) vshift_d = vshift_q + 3'd1;
          end else begin
            if (vshift_q != 3'd0) vshift_d = vshift_q - 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q     <= '0;
      vshift_q  <= '0;
      restore_q <= 1'b1;
    end else begin
      key_q     <= key_d;
      vshift_q  <= vshift_d;
      restore_q <= restore_d;
    end
  end

  always_comb begin
    eff = key_q;
    if (vshift_q != 3'd0) begin
      eff[SHIFT_ROW][SHIFT_COL] = 1'b1;
    end
    row_hit = '0;
    col_hit = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        row_hit[r] = row_hit[r] | (eff[r][c] & ~col_sel_n[c]);
        col_hit[c] = col_hit[c] | (eff[r][c] & ~row_sel_n[r]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_sense_n <= '1;
      col_sense_n <= '1;
    end else begin
      row_sense_n <= ~row_hit;
      col_sense_n <= ~col_hit;
    end
  end

endmodule

// File: tb/tb_c64_key_matrix.sv
// tb_c64_key_matrix: directed stimulus with an event-timeline model of the key matrix,
// compared against the DUT every cycle, plus literal spot checks.
module tb_c64_key_matrix;

  logic       clk;
  logic       reset_n;
  logic       key_strobe;
  logic [6:0] key_code;
  logic       key_pressed;
  logic [6:0] lk_code;
  logic [2:0] lk_row;
  logic [2:0] lk_col;
  logic [7:0] col_sel_n;
  logic [7:0] row_sense_n;
  logic [7:0] row_sel_n;
  logic [7:0] col_sense_n;
  logic       restore_n;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  c64_key_matrix dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .lk_code     (lk_code),
    .lk_row      (lk_row),
    .lk_col      (lk_col),
    .col_sel_n   (col_sel_n),
    .row_sense_n (row_sense_n),
    .row_sel_n   (row_sel_n),
    .col_sense_n (col_sense_n),
    .restore_n   (restore_n),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External code-to-position table: a few fixed placements, otherwise row=code[5:3], col=code[2:0].
  function automatic logic [5:0] lut(input logic [6:0] code);
    case (code)
      7'h04:   return {3'd2, 3'd1};
      7'h52:   return {3'd7, 3'd0};
      7'h50:   return {3'd7, 3'd2};
      7'h69:   return {3'd7, 3'd1};
      default: return code[5:0];
    endcase
  endfunction

  assign {lk_row, lk_col} = lut(lk_code);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [6:0] code;
    logic       press;
    int         a;      // edge at which the strobe was sampled
    int         entry;  // edge after which its code is on lk_code
    int         p;      // edge at which the matrix changes
    bit         held;
  } ev_t;

  ev_t        evq[$];
  bit         m_key[8][8];
  int         m_vs = 0;
  logic       m_restore_n = 1'b1;
  logic [6:0] m_lk = '0;
  logic [7:0] m_row = 8'hff;
  logic [7:0] m_col = 8'hff;
  logic       m_busy = 1'b0;
  int         k = 0;

  function automatic bit m_eff(input int r, input int c);
    return m_key[r][c] || (r == 7 && c == 1 && m_vs != 0);
  endfunction

  function automatic void m_apply(input logic [6:0] code, input logic press);
    logic [5:0] rc;
    int r, c;
    rc = lut(code);
    r  = int'(rc[5:3]);
    c  = int'(rc[2:0]);
    if (code == 7'h4a) begin
      m_restore_n = !press;
    end else if (code == 7'h01) begin
      foreach (m_key[i, j]) m_key[i][j] = 1'b0;
      m_vs = 0;
    end else if (((code >= 7'h04 && code <= 7'h64) || (code >= 7'h68 && code <= 7'h6f)) &&
                 r < 8 && c < 8) begin
      m_key[r][c] = press;
      if (code inside {7'h50, 7'h52, 7'h3b, 7'h3d, 7'h3f, 7'h41}) begin
        if (press) m_vs = (m_vs < 7) ? m_vs + 1 : 7;
        else       m_vs = (m_vs > 0) ? m_vs - 1 : 0;
      end
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit   busy_prev;
    bit   skid_prev;
    ev_t  ev;
    if (!reset_n) begin
      foreach (m_key[i, j]) m_key[i][j] = 1'b0;
      m_vs = 0; m_restore_n = 1'b1; m_lk = '0;
      m_row = 8'hff; m_col = 8'hff; m_busy = 1'b0;
      evq.delete();
    end else begin
      k++;
      m_row = 8'hff;
      m_col = 8'hff;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (m_eff(r, c)) begin
            if (!col_sel_n[c]) m_row[r] = 1'b0;
            if (!row_sel_n[r]) m_col[c] = 1'b0;
          end
      if (key_strobe) begin
        busy_prev = 0;
        skid_prev = 0;
        foreach (evq[i]) begin
          if (evq[i].a < k && evq[i].p >= k) busy_prev = 1;
          if (evq[i].held && evq[i].a == k - 1) skid_prev = 1;
        end
        ev.code = key_code; ev.press = key_pressed; ev.a = k;
        if (!busy_prev) begin
          ev.entry = k; ev.p = k + 1; ev.held = 0; evq.push_back(ev);
        end else if (!skid_prev) begin
          ev.entry = k + 1; ev.p = k + 2; ev.held = 1; evq.push_back(ev);
        end
      end
      foreach (evq[i]) begin
        if (evq[i].p == k) m_apply(evq[i].code, evq[i].press);
        if (evq[i].entry == k) m_lk = evq[i].code;
      end
      m_busy = 1'b0;
      foreach (evq[i]) if (evq[i].a <= k && evq[i].p > k) m_busy = 1'b1;
      while (evq.size() > 0 && evq[0].p < k) void'(evq.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("row_sense_n", row_sense_n, m_row);
    chk("col_sense_n", col_sense_n, m_col);
    chk("restore_n", {7'd0, restore_n}, {7'd0, m_restore_n});
    chk("busy", {7'd0, busy}, {7'd0, m_busy});
    chk("lk_code", {1'b0, lk_code}, {1'b0, m_lk});
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [6:0] code, input logic press);
    @(negedge clk);
    key_strobe  = 1'b1;
    key_code    = code;
    key_pressed = press;
    @(negedge clk);
    key_strobe  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1; key_strobe = 1'b0; key_code = '0; key_pressed = 1'b0;
    col_sel_n = 8'hff; row_sel_n = 8'hff;
    #1 reset_n = 1'b0;
    idle(2);
    chk("rst_row", row_sense_n, 8'hff);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_lk", {1'b0, lk_code}, 8'h00);
    chk("rst_restore", {7'd0, restore_n}, 8'h01);
    #2 reset_n = 1'b1;
    idle(2);

    // single press/release, both scan directions
    col_sel_n = 8'hfd;
    send(7'h04, 1'b1);
    chk("t1_busy", {7'd0, busy}, 8'h01);
    chk("t1_lk", {1'b0, lk_code}, 8'h04);
    idle(1);
    chk("t1_busy_fall", {7'd0, busy}, 8'h00);
    chk("t1_row_pre", row_sense_n, 8'hff);
    idle(1);
    chk("t1_row", row_sense_n, 8'hfb);
    row_sel_n = 8'hfb;
    idle(1);
    chk("t1_col", col_sense_n, 8'hfd);
    row_sel_n = 8'hff;
    send(7'h04, 1'b0);
    idle(2);
    chk("t1_rel", row_sense_n, 8'hff);

    // cursor up: key and virtual shift share row 7
    col_sel_n = 8'hfc;
    send(7'h52, 1'b1);
    idle(2);
    chk("t2_up", row_sense_n, 8'h7f);
    send(7'h52, 1'b0);
    idle(2);
    chk("t2_rel", row_sense_n, 8'hff);

    // physical and virtual shift are independent
    col_sel_n = 8'hfd;
    send(7'h69, 1'b1); idle(1);
    send(7'h50, 1'b1); idle(1);
    send(7'h69, 1'b0);
    idle(2);
    chk("t3_vshift_holds", row_sense_n, 8'h7f);
    send(7'h50, 1'b0);
    idle(2);
    chk("t3_rel", row_sense_n, 8'hff);

    // vshift counter saturates at 7 and at 0
    for (int i = 0; i < 8; i++) begin send(7'h3b, 1'b1); idle(1); end
    idle(1);
    chk("t3_sat7", row_sense_n, 8'h7f);
    for (int i = 0; i < 7; i++) begin send(7'h3b, 1'b0); idle(1); end
    idle(1);
    chk("t3_zero", row_sense_n, 8'hff);
    send(7'h3b, 1'b0); idle(1);
    send(7'h3b, 1'b1);
    idle(2);
    chk("t3_sat0_press", row_sense_n, 8'h7f);
    send(7'h3b, 1'b0);
    idle(2);
    chk("t3_sat0_rel", row_sense_n, 8'hff);

    // code class boundaries: 0x64,0x68 valid; 0x65,0x67 ignored
    col_sel_n = 8'h00;
    send(7'h64, 1'b1); idle(1);
    send(7'h65, 1'b1); idle(1);
    send(7'h67, 1'b1); idle(1);
    send(7'h68, 1'b1);
    idle(2);
    chk("t4_class_all", row_sense_n, 8'hcf);
    col_sel_n = 8'h5f;
    idle(1);
    chk("t4_ignored", row_sense_n, 8'hff);
    col_sel_n = 8'hee;
    idle(1);
    chk("t4_valid", row_sense_n, 8'hcf);

    // overrun (on release) clears everything
    col_sel_n = 8'h00;
    send(7'h01, 1'b0);
    idle(2);
    chk("t4_ovr_rel", row_sense_n, 8'hff);
    send(7'h0c, 1'b1); idle(1);
    send(7'h33, 1'b1);
    idle(2);
    chk("t4_two_keys", row_sense_n, 8'hbd);
    send(7'h01, 1'b1);
    idle(2);
    chk("t4_overrun", row_sense_n, 8'hff);

    // three back-to-back strobes: third is dropped
    @(negedge clk); key_strobe = 1'b1; key_code = 7'h08; key_pressed = 1'b1;
    @(negedge clk); key_code = 7'h11;
    chk("t5_busy1", {7'd0, busy}, 8'h01);
    @(negedge clk); key_code = 7'h1a;
    chk("t5_busy2", {7'd0, busy}, 8'h01);
    @(negedge clk); key_strobe = 1'b0;
    chk("t5_busy3", {7'd0, busy}, 8'h01);
    idle(1);
    chk("t5_busy_low", {7'd0, busy}, 8'h00);
    idle(1);
    chk("t5_rows", row_sense_n, 8'hf9);
    send(7'h08, 1'b0); idle(1);
    send(7'h11, 1'b0);
    idle(2);
    chk("t5_rel", row_sense_n, 8'hff);

    // RESTORE leaves the matrix alone
    send(7'h4a, 1'b1);
    idle(1);
    chk("t6_restore", {7'd0, restore_n}, 8'h00);
    idle(1);
    chk("t6_matrix", row_sense_n, 8'hff);
    send(7'h0c, 1'b1);
    idle(2);
    chk("t6_key", row_sense_n, 8'hfd);

    // reset in the middle of an event
    send(7'h33, 1'b1);
    chk("t6_busy_pre", {7'd0, busy}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_row", row_sense_n, 8'hff);
    chk("t6_rst_col", col_sense_n, 8'hff);
    chk("t6_rst_restore", {7'd0, restore_n}, 8'h01);
    chk("t6_rst_busy", {7'd0, busy}, 8'h00);
    chk("t6_rst_lk", {1'b0, lk_code}, 8'h00);
    idle(2);
    #2 reset_n = 1'b1;
    idle(3);
    chk("t6_post_rst", row_sense_n, 8'hff);
    chk("t6_post_busy", {7'd0, busy}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
